// File: rtl/pipe_hazard_pkg.sv
// pipe_hazard_pkg: shared scoreboard entry type and forwarding-select helpers
// for the pipeline hazard controller.
package pipe_hazard_pkg;

    // Scoreboard address field is sized for the widest register file supported.
    localparam int SB_AW  = 8;
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic             v;
        logic             vf;
        logic [SB_AW-1:0] addr;
        logic             ld;
    } sb_entry_t;

    function automatic int fwd_w(input int nstg);
        return $clog2(nstg + 1);
    endfunction

endpackage

// File: rtl/hz_scoreboard.sv
// hz_scoreboard: NSTG-deep shift register of in-flight register writes.
// Freezes on hold; the entry leaving the last stage is dropped.
module hz_scoreboard
    import pipe_hazard_pkg::*;
#(
    parameter int NSTG = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  sb_entry_t            ins,
    output sb_entry_t [NSTG-1:0] e
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e <= '0;
        end else if (!hold) begin
            e[0] <= ins;
            for (int k = 1; k < NSTG; k++) e[k] <= e[k-1];
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, operand forwarding, bubble and jump-flush
// control for the 5-stage pipeline, driven from a scoreboard of in-flight writes.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int REG_AW   = 4,
    parameter int NSTG     = 3,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [REG_AW-1:0]        id_src1,
    input  logic                     id_src1_vf,
    input  logic                     id_src1_used,
    input  logic [REG_AW-1:0]        id_src2,
    input  logic                     id_src2_vf,
    input  logic                     id_src2_used,
    input  logic [REG_AW-1:0]        id_dst,
    input  logic                     id_dst_vf,
    input  logic                     id_wreg,
    input  logic                     id_rmem,
    input  logic                     jmp_taken,
    input  logic                     ext_hold,
    output logic                     stall,
    output logic                     bubble,
    output logic                     flush,
    output logic [fwd_w(NSTG)-1:0]   fwd_sel1,
    output logic [fwd_w(NSTG)-1:0]   fwd_sel2,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         flush_cnt
);

    localparam int FW = fwd_w(NSTG);

    sb_entry_t [NSTG-1:0] e;
    sb_entry_t            ins;
    logic [NSTG-1:0]      m1, m2, early;
    logic                 hazard;

    function automatic logic hit(input sb_entry_t s, input logic used, input logic vf,
                                 input logic [REG_AW-1:0] a);
        return used && s.v && s.vf == vf && s.addr == SB_AW'(a)
               && !(ZERO_REG != 0 && !vf && a == '0);
    endfunction

    // Scanning oldest to youngest lets the youngest forwardable producer win.
    always_comb begin
        m1       = '0;
        m2       = '0;
        early    = '0;
        fwd_sel1 = FW'(FWD_RF);
        fwd_sel2 = FW'(FWD_RF);
        for (int k = NSTG - 1; k >= 0; k--) begin
            m1[k]    = hit(e[k], id_src1_used, id_src1_vf, id_src1);
            m2[k]    = hit(e[k], id_src2_used, id_src2_vf, id_src2);
            early[k] = e[k].ld && k < LOAD_LAT;
            if (m1[k] && !early[k]) fwd_sel1 = FW'(k + 1);
            if (m2[k] && !early[k]) fwd_sel2 = FW'(k + 1);
        end
        hazard = id_valid && |((m1 | m2) & early);
    end

    assign flush  = jmp_taken && !ext_hold;
    assign stall  = hazard && !flush && !ext_hold;
    assign bubble = stall;

    assign ins = '{v: id_valid && id_wreg && !stall && !flush, vf: id_dst_vf,
                   addr: SB_AW'(id_dst), ld: id_rmem};

    hz_scoreboard #(.NSTG(NSTG)) u_sb (
        .clk (clk),
        .rst (rst),
        .hold(ext_hold),
        .ins (ins),
        .e   (e)
    );

    // stall and flush are already gated by ext_hold, so counters freeze with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
            if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized checks of pipe_hazard_ctrl against
// a queue-of-issued-instructions reference model.
module tb_pipe_hazard_ctrl;

    localparam int AW   = 4;
    localparam int NSTG = 3;
    localparam int LL   = 1;
    localparam int CW   = 4;
    localparam int SAT  = (1 << CW) - 1;

    logic clk = 0;
    logic rst = 0;
    logic id_valid, id_src1_vf, id_src1_used, id_src2_vf, id_src2_used;
    logic id_dst_vf, id_wreg, id_rmem, jmp_taken, ext_hold;
    logic [AW-1:0] id_src1, id_src2, id_dst;
    logic stall, bubble, flush, z_stall, z_bubble, z_flush;
    logic [1:0] fwd_sel1, fwd_sel2, z_sel1, z_sel2;
    logic [CW-1:0] stall_cnt, flush_cnt, z_scnt, z_fcnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(AW), .NSTG(NSTG), .LOAD_LAT(LL), .ZERO_REG(1), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src1_vf(id_src1_vf), .id_src1_used(id_src1_used),
        .id_src2(id_src2), .id_src2_vf(id_src2_vf), .id_src2_used(id_src2_used),
        .id_dst(id_dst), .id_dst_vf(id_dst_vf), .id_wreg(id_wreg), .id_rmem(id_rmem),
        .jmp_taken(jmp_taken), .ext_hold(ext_hold),
        .stall(stall), .bubble(bubble), .flush(flush),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.REG_AW(AW), .NSTG(NSTG), .LOAD_LAT(LL), .ZERO_REG(0), .CNT_W(CW)) dut_z (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src1_vf(id_src1_vf), .id_src1_used(id_src1_used),
        .id_src2(id_src2), .id_src2_vf(id_src2_vf), .id_src2_used(id_src2_used),
        .id_dst(id_dst), .id_dst_vf(id_dst_vf), .id_wreg(id_wreg), .id_rmem(id_rmem),
        .jmp_taken(jmp_taken), .ext_hold(ext_hold),
        .stall(z_stall), .bubble(z_bubble), .flush(z_flush),
        .fwd_sel1(z_sel1), .fwd_sel2(z_sel2),
        .stall_cnt(z_scnt), .flush_cnt(z_fcnt)
    );

    // Reference model: every issued writer is remembered with the unheld-edge
    // tick at which it entered EX; its stage is simply the tick difference.
    typedef struct {
        int unsigned t;
        bit          inst;
        bit          vf;
        int          addr;
        bit          ld;
    } rec_t;

    rec_t        q[$];
    int unsigned tick = 0;
    int          m_sc = 0, m_sc1 = 0, m_fc = 0;

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    function automatic bit hit_m(input rec_t r, input bit used, input bit vf, input int a, input bit zr);
        if (!used || r.vf != vf || r.addr != a) return 0;
        return !(zr && !vf && a == 0);
    endfunction

    task automatic model(input bit inst, output bit haz, output int s1, output int s2);
        bit zr;
        int b1, b2;
        zr  = !inst;
        b1  = NSTG;
        b2  = NSTG;
        haz = 0;
        foreach (q[i]) begin
            int k;
            bit early;
            k = int'(tick - q[i].t);
            if (q[i].inst == inst && k < NSTG) begin
                early = q[i].ld && k < LL;
                if (hit_m(q[i], id_src1_used, id_src1_vf, int'(id_src1), zr)) begin
                    if (early) haz = 1;
                    else if (k < b1) b1 = k;
                end
                if (hit_m(q[i], id_src2_used, id_src2_vf, int'(id_src2), zr)) begin
                    if (early) haz = 1;
                    else if (k < b2) b2 = k;
                end
            end
        end
        haz = haz && id_valid;
        s1  = (b1 == NSTG) ? 0 : b1 + 1;
        s2  = (b2 == NSTG) ? 0 : b2 + 1;
    endtask

    always @(negedge rst) begin
        q.delete();
        m_sc  = 0;
        m_sc1 = 0;
        m_fc  = 0;
    end

    always @(negedge clk) begin : cmp
        bit   h0, h1, ef, es, es1;
        int   a1, a2, b1, b2;
        rec_t r;
        model(0, h0, a1, a2);
        model(1, h1, b1, b2);
        ef  = jmp_taken && !ext_hold;
        es  = h0 && !ef && !ext_hold;
        es1 = h1 && !ef && !ext_hold;
        chk("stall", int'(stall), int'(es));
        chk("bubble", int'(bubble), int'(es));
        chk("flush", int'(flush), int'(ef));
        chk("fwd_sel1", int'(fwd_sel1), a1);
        chk("fwd_sel2", int'(fwd_sel2), a2);
        chk("stall_cnt", int'(stall_cnt), m_sc);
        chk("flush_cnt", int'(flush_cnt), m_fc);
        chk("z_stall", int'(z_stall), int'(es1));
        chk("z_bubble", int'(z_bubble), int'(es1));
        chk("z_flush", int'(z_flush), int'(ef));
        chk("z_fwd_sel1", int'(z_sel1), b1);
        chk("z_fwd_sel2", int'(z_sel2), b2);
        chk("z_stall_cnt", int'(z_scnt), m_sc1);
        chk("z_flush_cnt", int'(z_fcnt), m_fc);
        if (rst && !ext_hold) begin
            tick++;
            r.t    = tick;
            r.vf   = id_dst_vf;
            r.addr = int'(id_dst);
            r.ld   = id_rmem;
            if (id_valid && id_wreg && !ef && !es) begin
                r.inst = 0;
                q.push_back(r);
            end
            if (id_valid && id_wreg && !ef && !es1) begin
                r.inst = 1;
                q.push_back(r);
            end
            if (es && m_sc < SAT) m_sc++;
            if (es1 && m_sc1 < SAT) m_sc1++;
            if (ef && m_fc < SAT) m_fc++;
            while (q.size() > 0 && tick - q[0].t >= NSTG) void'(q.pop_front());
        end
    end

    task automatic idle();
        id_valid = 0; id_src1 = '0; id_src1_vf = 0; id_src1_used = 0;
        id_src2 = '0; id_src2_vf = 0; id_src2_used = 0;
        id_dst = '0; id_dst_vf = 0; id_wreg = 0; id_rmem = 0;
        jmp_taken = 0; ext_hold = 0;
    endtask

    task automatic wr(input int d, input bit vf, input bit ld);
        id_valid = 1; id_wreg = 1; id_dst = AW'(d); id_dst_vf = vf; id_rmem = ld;
    endtask

    task automatic rd1(input int a, input bit vf);
        id_valid = 1; id_src1 = AW'(a); id_src1_vf = vf; id_src1_used = 1;
    endtask

    task automatic rd2(input int a, input bit vf);
        id_valid = 1; id_src2 = AW'(a); id_src2_vf = vf; id_src2_used = 1;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        chk("reset_stall", int'(stall), 0);
        chk("reset_fwd1", int'(fwd_sel1), 0);
        chk("reset_cnt", int'(stall_cnt), 0);
        // ALU forwarding from EX then MEM
        nxt(); wr(5, 0, 0);
        nxt(); rd1(5, 0);
        @(negedge clk);
        chk("alu_stall", int'(stall), 0);
        chk("alu_fwd_ex", int'(fwd_sel1), 1);
        nxt(); rd1(5, 0);
        @(negedge clk);
        chk("alu_fwd_mem", int'(fwd_sel1), 2);
        // vector load-use: one stall, then forward from MEM
        nxt(); wr(3, 1, 1);
        nxt(); rd2(3, 1);
        @(negedge clk);
        chk("ld_stall", int'(stall), 1);
        chk("ld_bubble", int'(bubble), 1);
        chk("ld_fwd2", int'(fwd_sel2), 0);
        nxt(); rd2(3, 1);
        @(negedge clk);
        chk("ld_stall_clear", int'(stall), 0);
        chk("ld_fwd2_mem", int'(fwd_sel2), 2);
        chk("ld_stall_cnt", int'(stall_cnt), 1);
        // banks are distinct
        nxt(); wr(3, 0, 0);
        nxt(); rd1(3, 1); rd2(3, 0);
        @(negedge clk);
        chk("bank_fwd1", int'(fwd_sel1), 0);
        chk("bank_fwd2", int'(fwd_sel2), 1);
        // register zero
        nxt(); wr(0, 0, 0);
        nxt(); rd1(0, 0);
        @(negedge clk);
        chk("r0_fwd_zr1", int'(fwd_sel1), 0);
        chk("r0_fwd_zr0", int'(z_sel1), 1);
        // load-use coinciding with a taken jump
        nxt(); wr(7, 0, 1);
        nxt(); rd1(7, 0); wr(9, 0, 0); jmp_taken = 1;
        @(negedge clk);
        chk("jmp_flush", int'(flush), 1);
        chk("jmp_stall", int'(stall), 0);
        nxt(); rd1(9, 0); rd2(7, 0);
        @(negedge clk);
        chk("jmp_young_dropped", int'(fwd_sel1), 0);
        chk("jmp_load_kept", int'(fwd_sel2), 2);
        chk("jmp_flush_cnt", int'(flush_cnt), 1);
        // hold over a pending hazard
        nxt(); wr(4, 0, 1);
        nxt(); rd1(4, 0); ext_hold = 1;
        repeat (3) begin
            @(negedge clk);
            chk("hold_stall", int'(stall), 0);
            @(posedge clk);
            #1;
        end
        ext_hold = 0;
        @(negedge clk);
        chk("hold_resume", int'(stall), 1);
        nxt(); rd1(4, 0);
        @(negedge clk);
        chk("hold_fwd", int'(fwd_sel1), 2);
        chk("hold_stall_cnt", int'(stall_cnt), 2);
        // drive stall_cnt into saturation
        repeat (16) begin
            nxt(); wr(6, 0, 1);
            nxt(); rd1(6, 0);
            nxt(); rd1(6, 0);
        end
        @(negedge clk);
        chk("sat_cnt", int'(stall_cnt), SAT);
        nxt(); wr(6, 0, 1);
        nxt(); rd1(6, 0);
        @(negedge clk);
        chk("sat_stall", int'(stall), 1);
        nxt();
        @(negedge clk);
        chk("sat_hold_max", int'(stall_cnt), SAT);
        // asynchronous reset in the middle of a stall
        nxt(); wr(2, 0, 1);
        nxt(); rd1(2, 0);
        @(negedge clk);
        chk("arst_pre", int'(stall), 1);
        #2 rst = 0;
        #1;
        chk("arst_stall", int'(stall), 0);
        chk("arst_scnt", int'(stall_cnt), 0);
        chk("arst_fcnt", int'(flush_cnt), 0);
        nxt(); rst = 1; rd1(2, 0);
        @(negedge clk);
        chk("post_rst_stall", int'(stall), 0);
        chk("post_rst_fwd", int'(fwd_sel1), 0);
        // randomized traffic
        repeat (3000) begin
            nxt();
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 0;
                @(posedge clk);
                #1 rst = 1;
            end
            id_valid     = $urandom_range(0, 9) != 0;
            id_src1      = AW'($urandom_range(0, 3));
            id_src1_vf   = $urandom_range(0, 3) == 0;
            id_src1_used = $urandom_range(0, 3) != 0;
            id_src2      = AW'($urandom_range(0, 3));
            id_src2_vf   = $urandom_range(0, 3) == 0;
            id_src2_used = $urandom_range(0, 3) != 0;
            id_dst       = AW'($urandom_range(0, 3));
            id_dst_vf    = $urandom_range(0, 3) == 0;
            id_wreg      = $urandom_range(0, 2) != 0;
            id_rmem      = $urandom_range(0, 2) == 0;
            jmp_taken    = $urandom_range(0, 11) == 0;
            ext_hold     = $urandom_range(0, 9) == 0;
        end
        nxt();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard, forwarding and flush controller for the 5-stage scalar/vector pipeline (IF, ID, EX, MEM, WB).
- Keeps a shift-register scoreboard of in-flight register writes.
- From that scoreboard it generates load-use stalls, per-operand forwarding selects, bubble injection and jump flushes.
- Sits beside the decode stage and drives the stall/flush controls of the IF/ID and ID/EX pipeline registers.

Parameters:
- REG_AW, 4, register address width (scalar and vector files alike).
- NSTG, 3, tracked stages after ID (index 0=EX, 1=MEM, 2=WB).
- LOAD_LAT, 1, stage index at which load data becomes forwardable (1 = end of MEM).
- ZERO_REG, 1, when 1 scalar register 0 never creates a hazard or a forward.
- CNT_W, 16, width of the performance counters.

Ports:
- clk in 1: clock.
- rst in 1: reset, asynchronous, active-low.
- id_valid in 1: ID holds a real instruction.
- id_src1 in REG_AW, id_src1_vf in 1, id_src1_used in 1: operand 1 address, bank, use flag.
- id_src2 in REG_AW, id_src2_vf in 1, id_src2_used in 1: operand 2 address, bank, use flag.
- id_dst in REG_AW, id_dst_vf in 1, id_wreg in 1, id_rmem in 1: destination, bank, write enable, is-load.
- jmp_taken in 1: jump resolved taken in EX.
- ext_hold in 1: global freeze (memory not ready).
- stall out 1: hold the PC and IF/ID.
- bubble out 1: insert a NOP into ID/EX.
- flush out 1: clear IF/ID and ID/EX.
- fwd_sel1 out $clog2(NSTG+1), fwd_sel2 out same: 0=regfile, k+1=result of stage k.
- stall_cnt out CNT_W, flush_cnt out CNT_W: saturating event counters.

Behaviour:
- Scoreboard entry e[k] for k=0..NSTG-1 holds {v, vf, addr, ld}.
- Reset (rst=0, asynchronous): all e[k].v=0 and both counters=0. Outputs therefore reset to stall=0, bubble=0, flush=0, fwd_sel=0.
- Match(src, k): src_used & e[k].v & (e[k].vf==src_vf) & (e[k].addr==src). Suppressed when ZERO_REG=1, vf=0 and addr=0.
- Load-use hazard: any used source matches some e[k] with e[k].ld=1 and k<LOAD_LAT, and id_valid=1.
- Outputs are combinational from the ID inputs and the registered scoreboard. Zero cycles of latency.
- flush = jmp_taken & ~ext_hold.
- stall = hazard & ~flush & ~ext_hold. bubble = stall.
- fwd_selN = smallest k+1 with Match(srcN,k) & ~(e[k].ld & k<LOAD_LAT); otherwise 0. The youngest producer always wins.
- When ext_hold=1, fwd_sel is still driven, but stall, bubble and flush are 0 and the scoreboard holds.
- Scoreboard update at each rising edge when ext_hold=0:
  - e[k] <= e[k-1] for k>=1. The entry leaving WB is dropped.
  - e[0] <= {id_valid & id_wreg & ~stall & ~flush, id_dst_vf, id_dst, id_rmem}.
- Flush keeps e[0]'s shift into e[1]: the jump itself proceeds. The younger instruction in ID is never recorded.
- Stall shifts normally and inserts an invalid e[0]. After the producing load reaches stage LOAD_LAT the hazard clears and the dependant issues with forwarding.
- Precedence: ext_hold > flush > stall.
- jmp_taken asserted during ext_hold is ignored. The EX stage keeps it asserted until the hold releases.
- Counters (update only when ext_hold=0, saturate at all-ones, never wrap):
  - stall_cnt +1 on each stall cycle.
  - flush_cnt +1 on each flush cycle.
- Reset mid-operation clears all in-flight tracking immediately. The first post-reset instruction sees no hazards.

Decomposition:
- Package pipe_hazard_pkg holds:
  - typedef sb_entry_t {v, vf, addr, ld}.
  - FWD_RF=0 constant.
  - function fwd_w(NSTG) returning $clog2(NSTG+1).
- One sub-module, hz_scoreboard: the NSTG-deep shift register with its hold/insert logic.
- Match, priority and counter logic stay in the top.

Test Plan:
- ALU writes scalar r5, next instruction reads r5 as src1 -> no stall, fwd_sel1=1. One cycle later the same read gives fwd_sel1=2.
- Load to vector v3, next instruction uses v3 as src2 (LOAD_LAT=1) -> stall=bubble=1 for exactly 1 cycle, then fwd_sel2=2, stall_cnt=1.
- Scalar r3 in flight, ID reads vector v3 -> no match, fwd_sel=0.
- ZERO_REG=1, write r0 then read r0 -> fwd_sel=0. ZERO_REG=0 -> fwd_sel=1.
- Load-use hazard in the same cycle as jmp_taken=1 -> flush=1, stall=0, e[0] invalid next cycle, flush_cnt=1.
- ext_hold=1 for 3 cycles during a pending hazard -> scoreboard frozen, stall=0 throughout. The hazard resumes after release. Also force stall_cnt to its maximum (0xFFFF) and stall once more -> stays at 0xFFFF. Assert rst=0 asynchronously mid-stall -> stall drops immediately and counters read 0.
